// File: rtl/memory_btn_debounce_if.sv
// memory_btn_debounce_if: raw buttons in, game-core pulses and debounced levels out
interface memory_btn_debounce_if;
  logic BtnR, BtnL, BtnU, BtnD, BtnC;
  logic Right, Left, Up, Down, Select, Drop;
  logic [4:0] Held;
  modport master (
    output BtnR, BtnL, BtnU, BtnD, BtnC,
    input  Right, Left, Up, Down, Select, Drop, Held
  );
  modport slave (
    input  BtnR, BtnL, BtnU, BtnD, BtnC,
    output Right, Left, Up, Down, Select, Drop, Held
  );
endinterface

// File: rtl/memory_btn_debounce.sv
// memory_btn_debounce: synchronize, debounce and priority-arbitrate five buttons into one-clock pulses
module memory_btn_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input logic Clk,
  input logic Reset,
  memory_btn_debounce_if.slave bus
);
  typedef enum logic [2:0] {INI, W84, SCEN, WS, CCR} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic [4:0] w_raw, w_req, w_held, w_win;
  logic [4:0] r_s1, r_s2, r_pulse;
  logic r_drop;
  assign w_raw = {bus.BtnC, bus.BtnD, bus.BtnU, bus.BtnL, bus.BtnR};
  always_ff @(posedge Clk) begin
    r_s1 <= Reset ? '0 : w_raw;
    r_s2 <= Reset ? '0 : r_s1;
  end
  for (genvar g = 0; g < 5; g++) begin : g_ch
    state_t r_st;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_st <= INI;
        r_cnt <= '0;
      end else begin
        case (r_st)
          INI: if (r_s2[g]) begin
            r_st <= W84;
            r_cnt <= '0;
          end
          W84: if (!r_s2[g]) r_st <= INI;
               else if (r_cnt == LAST) r_st <= SCEN;
               else r_cnt <= r_cnt + 1'b1;
          SCEN: r_st <= WS;
          WS: if (!r_s2[g]) begin
            r_st <= CCR;
            r_cnt <= '0;
          end
          CCR: if (r_s2[g]) r_st <= WS;
               else if (r_cnt == LAST) r_st <= INI;
               else r_cnt <= r_cnt + 1'b1;
          default: r_st <= INI;
        endcase
      end
    end
    assign w_req[g] = r_st == SCEN;
    assign w_held[g] = r_st == SCEN || r_st == WS || r_st == CCR;
  end
  always_comb begin
    w_win = w_req[4] ? 5'b10000 :
            w_req[2] ? 5'b00100 :
            w_req[3] ? 5'b01000 :
            w_req[1] ? 5'b00010 : {4'b0000, w_req[0]};
  end
  always_ff @(posedge Clk) begin
    r_pulse <= Reset ? '0 : w_win;
    r_drop <= Reset ? 1'b0 : $countones(w_req) > 1;
  end
  assign {bus.Select, bus.Down, bus.Up, bus.Left, bus.Right} = r_pulse;
  assign bus.Drop = r_drop;
  assign bus.Held = w_held;
endmodule

// File: tb/tb_memory_btn_debounce.sv
// tb_memory_btn_debounce: randomized bounce/press stimulus against an edge-timing reference model
module tb_memory_btn_debounce;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_edge = -1;
  logic [5:0] exp_vec = '0;
  logic [4:0] seq [12] = '{5'd16, 5'd1, 5'd8, 5'd16, 5'd1, 5'd16, 5'd4, 5'd16, 5'd1, 5'd8, 5'd8, 5'd16};
  memory_btn_debounce_if bus ();
  memory_btn_debounce #(.DB_CYCLES(DB), .CNT_W(3)) dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s at edge %0d: got %b expected %b", tag, cyc, got, want);
  endtask
  function automatic logic [5:0] model(input logic [4:0] sub);
    int ord [5] = '{4, 2, 3, 1, 0};
    logic [4:0] w = '0;
    for (int i = 0; i < 5; i++) if (sub[ord[i]] && w == 5'd0) w[ord[i]] = 1'b1;
    return {w, $countones(sub) > 1};
  endfunction
  task automatic tick(input logic [4:0] raw, input logic r = 1'b0);
    @(negedge clk);
    {bus.BtnC, bus.BtnD, bus.BtnU, bus.BtnL, bus.BtnR} = raw;
    rst = r;
    @(posedge clk);
    cyc++;
    #1;
    chk("pulses", {bus.Select, bus.Down, bus.Up, bus.Left, bus.Right, bus.Drop},
        cyc == exp_edge ? exp_vec : 6'd0);
  endtask
  task automatic release_btn(input logic [4:0] sub);
    int m;
    repeat ($urandom_range(0, 2)) begin
      repeat ($urandom_range(1, 2)) tick(5'd0);
      repeat ($urandom_range(1, 2)) tick(sub);
    end
    m = cyc + 1;
    repeat (DB + 8) begin
      tick(5'd0);
      if (cyc == m + DB + 1) chk("held_release", {1'b0, bus.Held}, {1'b0, sub});
      if (cyc == m + DB + 3) chk("held_off", {1'b0, bus.Held}, 6'd0);
    end
  endtask
  task automatic press(input logic [4:0] sub, input int hold);
    int s;
    repeat ($urandom_range(0, 2)) begin
      repeat ($urandom_range(1, DB - 1)) tick(sub);
      repeat ($urandom_range(1, 2)) tick(5'd0);
    end
    s = cyc + 1;
    exp_vec = model(sub);
    exp_edge = s + DB + 3;
    repeat (hold) begin
      tick(sub);
      if (cyc == s + DB + 1) chk("held_wait", {1'b0, bus.Held}, 6'd0);
      if (cyc == s + DB + 2) chk("held_on", {1'b0, bus.Held}, {1'b0, sub});
    end
    release_btn(sub);
  endtask
  initial begin
    int s;
    {bus.BtnC, bus.BtnD, bus.BtnU, bus.BtnL, bus.BtnR} = 5'd0;
    tick(5'd0, 1'b1);
    tick(5'd0, 1'b1);
    chk("held_reset", {1'b0, bus.Held}, 6'd0);
    repeat (5) tick(5'd0);
    press(5'b00001, 30);
    press(5'b00100, 15);
    press(5'b11000, 15);
    press(5'b00010, 200);
    repeat (4) tick(5'b10000);
    tick(5'b10000, 1'b1);
    chk("held_mid_reset", {1'b0, bus.Held}, 6'd0);
    s = cyc + 1;
    exp_vec = 6'b100000;
    exp_edge = s + DB + 3;
    repeat (20) tick(5'b10000);
    chk("held_after_reset", {1'b0, bus.Held}, 6'b010000);
    release_btn(5'b10000);
    foreach (seq[i]) press(seq[i], 20);
    repeat (25) press(5'($urandom_range(1, 31)), int'($urandom_range(DB + 6, 3 * DB)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
